seq_player_matcher: RTL and testbench

- Per-player sequence-entry engine for the timed two-player memory game. One instance runs per player.
- Each instance latches the target 4-symbol sequence when a round starts and times the round. It compares the player's key strokes step by step.
- It drives the 4-bit progress vector that the winner checker reads as A or B. The value 4'b1111 means the full sequence has been matched.

---
 rtl/seq_player_matcher_if.sv | 33 +++
 rtl/seq_player_matcher.sv | 156 +++++++++++++++
 tb/tb_seq_player_matcher.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/seq_player_matcher_if.sv
// ============================================================================
// Module : seq_player_matcher_if
// Brief  : Round-control and progress bus between game controller and the
//          per-player sequence matcher.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface seq_player_matcher_if;
  logic        Start;
  logic [15:0] Pattern;
  logic [3:0]  Key;
  logic        KeyValid;
  logic [3:0]  Prog;
  logic        Done;
  logic        TimedOut;
  logic        Failed;
  logic        Busy;
  logic [15:0] TimeLeft;
  logic [2:0]  Misses;

  modport master (
    output Start, Pattern, Key, KeyValid,
    input  Prog, Done, TimedOut, Failed, Busy, TimeLeft, Misses
  );

  modport slave (
    input  Start, Pattern, Key, KeyValid,
    output Prog, Done, TimedOut, Failed, Busy, TimeLeft, Misses
  );
endinterface

`default_nettype wire

// File: rtl/seq_player_matcher.sv
// ============================================================================
// Module : seq_player_matcher
// Brief  : Per-player 4-step sequence-entry engine with round timer and
//          wrong-key limit; drives the progress vector read by the checker.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module seq_player_matcher #(
  parameter logic [15:0] TIMEOUT  = 16'd50000,
  parameter int          MAX_MISS = 3
) (
  input  wire                  Clk,
  input  wire                  Rst,
  seq_player_matcher_if.slave  bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RUN  = 3'd1;
  localparam logic [2:0] S_DONE = 3'd2;
  localparam logic [2:0] S_TOUT = 3'd3;
  localparam logic [2:0] S_FAIL = 3'd4;

  localparam logic [2:0] C_MAX_MISS = 3'(MAX_MISS);

  logic [2:0]  state_q, state_d;
  logic [15:0] pat_q, pat_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  prog_q, prog_d;
  logic        done_q, done_d;
  logic        tout_q, tout_d;
  logic        fail_q, fail_d;
  logic        busy_q, busy_d;
  logic [15:0] tl_q, tl_d;
  logic [2:0]  miss_q, miss_d;

  logic [3:0]  w_sym;
  logic [2:0]  w_miss_inc;

  assign w_sym      = pat_q[{idx_q, 2'b00} +: 4];
  assign w_miss_inc = miss_q + 3'd1;

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    idx_d   = idx_q;
    prog_d  = prog_q;
    done_d  = done_q;
    tout_d  = tout_q;
    fail_d  = fail_q;
    busy_d  = busy_q;
    tl_d    = tl_q;
    miss_d  = miss_q;

    case (state_q)
      S_IDLE: begin
        if (bus.Start) begin
          state_d = S_RUN;
          pat_d   = bus.Pattern;
          idx_d   = 2'd0;
          prog_d  = 4'd0;
          miss_d  = 3'd0;
          done_d  = 1'b0;
          tout_d  = 1'b0;
          fail_d  = 1'b0;
          tl_d    = TIMEOUT;
          busy_d  = 1'b1;
        end
      end

      S_RUN: begin
        if (!bus.Start) begin
          state_d = S_IDLE;
          idx_d   = 2'd0;
          prog_d  = 4'd0;
          miss_d  = 3'd0;
          tl_d    = 16'd0;
          busy_d  = 1'b0;
          done_d  = 1'b0;
          tout_d  = 1'b0;
          fail_d  = 1'b0;
        end else if (tl_q == 16'd0) begin
          // Timer expiry beats any key strobed in the same cycle.
          state_d = S_TOUT;
          tout_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          tl_d = tl_q - 16'd1;
          if (bus.KeyValid) begin
            if (bus.Key == w_sym) begin
              prog_d[idx_q] = 1'b1;
              idx_d         = idx_q + 2'd1;
              if (idx_q == 2'd3) begin
                state_d = S_DONE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
              end
            end else begin
              prog_d = 4'd0;
              idx_d  = 2'd0;
              miss_d = w_miss_inc;
              if (w_miss_inc == C_MAX_MISS) begin
                state_d = S_FAIL;
                fail_d  = 1'b1;
                busy_d  = 1'b0;
              end
            end
          end
        end
      end

      S_DONE, S_TOUT, S_FAIL: begin
        if (!bus.Start) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= S_IDLE;
      pat_q   <= 16'd0;
      idx_q   <= 2'd0;
      prog_q  <= 4'd0;
      done_q  <= 1'b0;
      tout_q  <= 1'b0;
      fail_q  <= 1'b0;
      busy_q  <= 1'b0;
      tl_q    <= 16'd0;
      miss_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      idx_q   <= idx_d;
      prog_q  <= prog_d;
      done_q  <= done_d;
      tout_q  <= tout_d;
      fail_q  <= fail_d;
      busy_q  <= busy_d;
      tl_q    <= tl_d;
      miss_q  <= miss_d;
    end
  end

  assign bus.Prog     = prog_q;
  assign bus.Done     = done_q;
  assign bus.TimedOut = tout_q;
  assign bus.Failed   = fail_q;
  assign bus.Busy     = busy_q;
  assign bus.TimeLeft = tl_q;
  assign bus.Misses   = miss_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_player_matcher.sv
// ============================================================================
// Module : tb_seq_player_matcher
// Brief  : Directed self-checking bench for seq_player_matcher (TIMEOUT=8).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_seq_player_matcher;

  logic Clk;
  logic Rst;
  int   total;
  int   bad;

  seq_player_matcher_if bus ();

  seq_player_matcher #(
    .TIMEOUT  (16'd8),
    .MAX_MISS (3)
  ) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Flags packed as {Prog, Done, TimedOut, Failed, Busy, Misses}
  function automatic logic [31:0] st();
    return {21'd0, bus.Prog, bus.Done, bus.TimedOut, bus.Failed, bus.Busy, bus.Misses};
  endfunction

  function automatic logic [31:0] mk(input logic [3:0] p, input logic d, input logic t,
                                     input logic f, input logic b, input logic [2:0] m);
    return {21'd0, p, d, t, f, b, m};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic key(input logic [3:0] k);
    bus.Key      = k;
    bus.KeyValid = 1'b1;
    step();
    bus.KeyValid = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // Reset with arbitrary inputs
    Rst          = 1'b0;
    bus.Start    = 1'b1;
    bus.Pattern  = 16'($urandom);
    bus.Key      = 4'($urandom);
    bus.KeyValid = 1'b1;
    #3;
    check("rst_async_flags", st(), mk(4'h0, 0, 0, 0, 0, 3'd0));
    check("rst_async_tl", {16'd0, bus.TimeLeft}, 32'd0);
    step();
    check("rst_held_flags", st(), mk(4'h0, 0, 0, 0, 0, 3'd0));
    bus.Start    = 1'b0;
    bus.KeyValid = 1'b0;
    #2;
    Rst = 1'b1;
    step();
    step();
    check("idle_after_rst", st(), mk(4'h0, 0, 0, 0, 0, 3'd0));

    // Full match
    bus.Pattern = 16'h5A3C;
    bus.Start   = 1'b1;
    step();
    check("run_entry", st(), mk(4'h0, 0, 0, 0, 1, 3'd0));
    check("run_entry_tl", {16'd0, bus.TimeLeft}, 32'd8);
    bus.Pattern = 16'hFFFF;
    key(4'hC); check("fm_k0", st(), mk(4'b0001, 0, 0, 0, 1, 3'd0));
    check("fm_tl", {16'd0, bus.TimeLeft}, 32'd7);
    key(4'h3); check("fm_k1", st(), mk(4'b0011, 0, 0, 0, 1, 3'd0));
    key(4'hA); check("fm_k2", st(), mk(4'b0111, 0, 0, 0, 1, 3'd0));
    key(4'h5); check("fm_k3", st(), mk(4'b1111, 1, 0, 0, 0, 3'd0));
    key(4'h0); step();
    check("fm_hold", st(), mk(4'b1111, 1, 0, 0, 0, 3'd0));
    bus.Start = 1'b0;
    step();
    check("fm_idle_hold", st(), mk(4'b1111, 1, 0, 0, 0, 3'd0));

    // Mismatch recovery
    bus.Pattern = 16'h5A3C;
    bus.Start   = 1'b1;
    step();
    check("mm_entry", st(), mk(4'h0, 0, 0, 0, 1, 3'd0));
    key(4'hC); key(4'h3);
    check("mm_k1", st(), mk(4'b0011, 0, 0, 0, 1, 3'd0));
    key(4'h7);
    check("mm_wrong", st(), mk(4'b0000, 0, 0, 0, 1, 3'd1));
    key(4'hC); key(4'h3); key(4'hA); key(4'h5);
    check("mm_done", st(), mk(4'b1111, 1, 0, 0, 0, 3'd1));
    bus.Start = 1'b0;
    step();

    // Miss limit
    bus.Start = 1'b1;
    step();
    key(4'h1);
    check("ml_m1", st(), mk(4'h0, 0, 0, 0, 1, 3'd1));
    key(4'h1); key(4'h1);
    check("ml_fail", st(), mk(4'h0, 0, 0, 1, 0, 3'd3));
    key(4'hC);
    check("ml_ignore", st(), mk(4'h0, 0, 0, 1, 0, 3'd3));
    bus.Start = 1'b0;
    step();

    // Timeout: RUN entered on E0, expiry seen after E9
    bus.Start = 1'b1;
    step();
    key(4'hC);
    for (int i = 0; i < 7; i++) step();
    check("to_pre", st(), mk(4'b0001, 0, 0, 0, 1, 3'd0));
    check("to_pre_tl", {16'd0, bus.TimeLeft}, 32'd0);
    key(4'h3);
    check("to_hit", st(), mk(4'b0001, 0, 1, 0, 0, 3'd0));
    bus.Start = 1'b0;
    step();

    // Abort mid-RUN
    bus.Start = 1'b1;
    step();
    key(4'hC); key(4'h3);
    check("ab_pre", st(), mk(4'b0011, 0, 0, 0, 1, 3'd0));
    bus.Start = 1'b0;
    step();
    check("ab_idle", st(), mk(4'h0, 0, 0, 0, 0, 3'd0));
    check("ab_tl", {16'd0, bus.TimeLeft}, 32'd0);

    // Async reset between edges
    bus.Start = 1'b1;
    step();
    key(4'hC);
    check("ar_pre", st(), mk(4'b0001, 0, 0, 0, 1, 3'd0));
    #2;
    Rst = 1'b0;
    #1;
    check("ar_clear", st(), mk(4'h0, 0, 0, 0, 0, 3'd0));
    check("ar_tl", {16'd0, bus.TimeLeft}, 32'd0);
    Rst = 1'b1;
    step();
    check("ar_restart", st(), mk(4'h0, 0, 0, 0, 1, 3'd0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
